// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared widths, source encoding and arbitration limit for the
//            register-file write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int NUM_REGS      = 2 ** RF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } src_e;

    // Consecutive LSU wins tolerated while an ALU result waits at its head.
    localparam logic [1:0] LSU_STREAK_MAX = 2'd2;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_if
// Purpose  : Producer handshakes, issue notification, busy bitmap and
//            register-file write port of the write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_writeback_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDR_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]      alu_data;

    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [ADDR_WIDTH-1:0]      lsu_rd;
    logic [DATA_WIDTH-1:0]      lsu_data;

    logic                       issue_valid;
    logic [ADDR_WIDTH-1:0]      issue_rd;
    logic [(2**ADDR_WIDTH)-1:0] busy;

    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_rd;
    logic [DATA_WIDTH-1:0]      rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready, busy,
        input  rf_wen, rf_rd, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready, busy,
        output rf_wen, rf_rd, rf_wdata
    );

endinterface : rf_writeback_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Small synchronous FIFO buffering one producer's results;
//            full/empty distinguished by an extra pointer bit.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_pop_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                        (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign o_pop_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_push_data;
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback
// Purpose  : Write-back stage: buffers ALU/LSU results, arbitrates one
//            register-file write per cycle, tracks pending-write busy bits.
// Revision : 1.0 - initial release
// ============================================================================
module rf_writeback
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    rf_writeback_if.slave bus
);

    localparam int c_entry_w  = ADDR_WIDTH + DATA_WIDTH;
    localparam int c_num_regs = 2 ** ADDR_WIDTH;

    logic                  w_alu_full;
    logic                  w_alu_empty;
    logic [c_entry_w-1:0]  w_alu_head;
    logic                  w_lsu_full;
    logic                  w_lsu_empty;
    logic [c_entry_w-1:0]  w_lsu_head;

    src_e                  w_winner;
    logic [c_entry_w-1:0]  w_win_entry;
    logic [ADDR_WIDTH-1:0] w_win_rd;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [c_num_regs-1:0] w_busy_next;

    logic [1:0]            r_lsu_streak;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_num_regs-1:0] r_busy;

    wb_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (bus.alu_valid),
        .i_push_data ({bus.alu_rd, bus.alu_data}),
        .i_pop       (w_winner == SRC_ALU),
        .o_pop_data  (w_alu_head),
        .o_full      (w_alu_full),
        .o_empty     (w_alu_empty)
    );

    wb_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (bus.lsu_valid),
        .i_push_data ({bus.lsu_rd, bus.lsu_data}),
        .i_pop       (w_winner == SRC_LSU),
        .o_pop_data  (w_lsu_head),
        .o_full      (w_lsu_full),
        .o_empty     (w_lsu_empty)
    );

    assign bus.alu_ready = !w_alu_full;
    assign bus.lsu_ready = !w_lsu_full;

    // LSU wins unless the ALU head has already been passed over LSU_STREAK_MAX times.
    always_comb begin
        w_winner = SRC_NONE;
        if (!w_lsu_empty && !(!w_alu_empty && (r_lsu_streak == LSU_STREAK_MAX))) begin
            w_winner = SRC_LSU;
        end else if (!w_alu_empty) begin
            w_winner = SRC_ALU;
        end
    end

    assign w_win_entry = (w_winner == SRC_LSU) ? w_lsu_head : w_alu_head;
    assign w_win_rd    = w_win_entry[c_entry_w-1 -: ADDR_WIDTH];
    assign w_win_data  = w_win_entry[DATA_WIDTH-1:0];

    // A new issue to the register being written this edge keeps its bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (r_wen) begin
            w_busy_next[r_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            w_busy_next[bus.issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsu_streak <= 2'd0;
            r_wen        <= 1'b0;
            r_rd         <= '0;
            r_wdata      <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_next;

            if (w_alu_empty || (w_winner == SRC_ALU)) begin
                r_lsu_streak <= 2'd0;
            end else if (w_winner == SRC_LSU) begin
                r_lsu_streak <= r_lsu_streak + 2'd1;
            end

            // Writes to x0 are consumed but never reach the register file.
            if ((w_winner != SRC_NONE) && (w_win_rd != '0)) begin
                r_wen   <= 1'b1;
                r_rd    <= w_win_rd;
                r_wdata <= w_win_data;
            end else begin
                r_wen   <= 1'b0;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.rf_wen   = r_wen;
    assign bus.rf_rd    = r_rd;
    assign bus.rf_wdata = r_wdata;

endmodule : rf_writeback
`default_nettype wire
